// File: rtl/eth_tx_framer.sv
// eth_tx_framer -- transmit-side Ethernet framer, one per channel.
//
// Builds dst MAC | src MAC | EtherType | payload | zero pad | FCS from a
// per-frame header and an AXI-stream payload, and drives the logic-side
// TX port of mac_rgmii. Preamble/SFD are inserted downstream on sof.
// Upstream underrun or oversize closes the frame with an inverted FCS so
// the far end drops it; any remaining payload is then drained.
//
// Ports:
//   mac_tx_clk, rst        byte clock, async active-high reset
//   dst_mac/src_mac/eth_type  header fields, latched at frame start
//   s_axis_*               payload stream (tready combinational)
//   mac_tx_data/valid/sof/eof  registered frame byte stream
//   tx_busy                not idle, or inter-frame gap still running
//   tx_done / tx_err       one-cycle pulse with eof (good / aborted)
//   frame_cnt              good frames sent, wraps
module eth_tx_framer #(
  parameter int IFG_CYCLES  = 20,
  parameter int MAX_PAYLOAD = 1500,
  parameter int MIN_PAYLOAD = 46
) (
  input  logic        mac_tx_clk,
  input  logic        rst,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] eth_type,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [7:0]  mac_tx_data,
  output logic        mac_tx_valid,
  output logic        mac_tx_sof,
  output logic        mac_tx_eof,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_err,
  output logic [15:0] frame_cnt
);

  localparam int IW = $clog2(IFG_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAY, S_PAD, S_FCS, S_DRAIN} state_t;

  state_t        state;
  logic [103:0]  hdr_sr;    // header bytes 1..13, MSB byte next
  logic [3:0]    hdr_cnt;
  logic [10:0]   pay_cnt;   // payload + pad bytes emitted so far
  logic [1:0]    fcs_idx;
  logic          err_f;     // frame is being aborted
  logic          term_f;    // tlast already accepted for this frame
  logic [31:0]   crc;       // running CRC over every byte already emitted
  logic [IW-1:0] ifg_cnt;   // 0 = gap satisfied
  logic [31:0]   fcs_word;
  logic [10:0]   pay_nxt;

  // Reflected CRC-32, one byte, LSB first.
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign s_axis_tready = (state == S_PAY) || (state == S_DRAIN);
  assign tx_busy       = (state != S_IDLE) || (ifg_cnt != '0);
  // Correct FCS is ~crc; an aborted frame sends its complement, i.e. crc.
  assign fcs_word      = err_f ? crc : ~crc;
  assign pay_nxt       = pay_cnt + 11'd1;

  always_ff @(posedge mac_tx_clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      hdr_sr       <= '0;
      hdr_cnt      <= '0;
      pay_cnt      <= '0;
      fcs_idx      <= '0;
      err_f        <= 1'b0;
      term_f       <= 1'b0;
      crc          <= 32'hFFFFFFFF;
      ifg_cnt      <= '0;
      mac_tx_data  <= '0;
      mac_tx_valid <= 1'b0;
      mac_tx_sof   <= 1'b0;
      mac_tx_eof   <= 1'b0;
      tx_done      <= 1'b0;
      tx_err       <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      mac_tx_sof <= 1'b0;
      mac_tx_eof <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
      // Gap countdown runs in every state, including DRAIN.
      if (ifg_cnt != '0) ifg_cnt <= ifg_cnt - 1'b1;

      case (state)
        S_IDLE: begin
          mac_tx_valid <= 1'b0;
          mac_tx_data  <= '0;
          // Start costs no payload byte: header byte 0 goes out from the ports.
          if (s_axis_tvalid && (ifg_cnt == '0)) begin
            hdr_sr       <= {dst_mac[39:0], src_mac, eth_type};
            mac_tx_data  <= dst_mac[47:40];
            mac_tx_valid <= 1'b1;
            mac_tx_sof   <= 1'b1;
            crc          <= crc_upd(32'hFFFFFFFF, dst_mac[47:40]);
            hdr_cnt      <= '0;
            pay_cnt      <= '0;
            fcs_idx      <= '0;
            err_f        <= 1'b0;
            term_f       <= 1'b0;
            state        <= S_HDR;
          end
        end

        S_HDR: begin
          mac_tx_data <= hdr_sr[103:96];
          crc         <= crc_upd(crc, hdr_sr[103:96]);
          hdr_sr      <= {hdr_sr[95:0], 8'h00};
          hdr_cnt     <= hdr_cnt + 4'd1;
          if (hdr_cnt == 4'd12) state <= S_PAY;
        end

        S_PAY: begin
          if (s_axis_tvalid) begin
            mac_tx_data <= s_axis_tdata;
            crc         <= crc_upd(crc, s_axis_tdata);
            pay_cnt     <= pay_nxt;
            if (s_axis_tlast) begin
              term_f <= 1'b1;
              state  <= (pay_nxt < 11'(MIN_PAYLOAD)) ? S_PAD : S_FCS;
            end else if (pay_nxt == 11'(MAX_PAYLOAD)) begin
              err_f <= 1'b1;
              state <= S_FCS;
            end
          end else begin
            // Underrun: go straight to the (inverted) FCS so valid never gaps.
            mac_tx_data <= crc[7:0];
            err_f       <= 1'b1;
            fcs_idx     <= 2'd1;
            state       <= S_FCS;
          end
        end

        S_PAD: begin
          mac_tx_data <= 8'h00;
          crc         <= crc_upd(crc, 8'h00);
          pay_cnt     <= pay_nxt;
          if (pay_nxt == 11'(MIN_PAYLOAD)) state <= S_FCS;
        end

        S_FCS: begin
          mac_tx_data <= fcs_word[8*fcs_idx +: 8];
          fcs_idx     <= fcs_idx + 2'd1;
          if (fcs_idx == 2'd3) begin
            mac_tx_eof <= 1'b1;
            ifg_cnt    <= IW'(IFG_CYCLES - 1);
            if (err_f) begin
              tx_err <= 1'b1;
            end else begin
              tx_done   <= 1'b1;
              frame_cnt <= frame_cnt + 16'd1;
            end
            state <= (err_f && !term_f) ? S_DRAIN : S_IDLE;
          end
        end

        S_DRAIN: begin
          mac_tx_valid <= 1'b0;
          mac_tx_data  <= '0;
          if (s_axis_tvalid && s_axis_tlast) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
